// File: rtl/div_core_radix2_et.sv
// rtl/div_core_radix2_et.sv - unsigned radix-2 restoring divider with early termination
// Divisor is pre-aligned to the dividend MSB so only significant quotient bits are iterated.
module div_core_radix2_et #(
   parameter int DIV_WIDTH = 32,
   localparam int CW = $clog2(DIV_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [CW-1:0]        dividend_CLZ,
   input  logic [CW-1:0]        divisor_CLZ,
   input  logic                 divisor_is_zero,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_WIDTH-1:0] quotient,
   output logic [DIV_WIDTH-1:0] remainder
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q;
   logic                 done_q;
   logic [DIV_WIDTH-1:0] quotient_q, remainder_q;
   logic [DIV_WIDTH-1:0] rem_q, div_q, quo_q;
   logic [CW-1:0]        cnt_q;

   logic                 ge;
   logic [DIV_WIDTH-1:0] rem_d, quo_d;
   logic [CW-1:0]        shift_d;

   always_comb begin
      ge      = (rem_q >= div_q);
      rem_d   = ge ? (rem_q - div_q) : rem_q;
      quo_d   = {quo_q[DIV_WIDTH-2:0], ge};
      // Only meaningful when divisor_CLZ >= dividend_CLZ, i.e. on the iterative path.
      shift_d = divisor_CLZ - dividend_CLZ;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (divisor_is_zero) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     done_q      <= 1'b1;
                  end else if (divisor_CLZ < dividend_CLZ) begin
                     quotient_q  <= '0;
                     remainder_q <= dividend;
                     done_q      <= 1'b1;
                  end else begin
                     rem_q   <= dividend;
                     div_q   <= divisor << shift_d;
                     quo_q   <= '0;
                     cnt_q   <= shift_d;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               rem_q <= rem_d;
               div_q <= div_q >> 1;
               quo_q <= quo_d;
               if (cnt_q == '0) begin
                  state_q     <= IDLE;
                  done_q      <= 1'b1;
                  quotient_q  <= quo_d;
                  remainder_q <= rem_d;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

   a_no_start_while_busy: assert property (@(posedge clk) disable iff (rst) !(start && busy));

endmodule
